// File: rtl/sp_sync_ram_pkg.sv
// rtl/sp_sync_ram_pkg.sv - shared default geometry of the main-memory RAM
package sp_sync_ram_pkg;

    localparam int MEM_DATA_WIDTH = 32;
    localparam int MEM_ADDR_WIDTH = 28;

endpackage

// File: rtl/sp_sync_ram_array.sv
// rtl/sp_sync_ram_array.sv - storage array with registered read port
module sp_sync_ram_array
    import sp_sync_ram_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Array itself is never reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sp_sync_ram.sv
// rtl/sp_sync_ram.sv - single-port synchronous RAM on a shared tri-state data bus
module sp_sync_ram
    import sp_sync_ram_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe
);

    logic [DATA_WIDTH-1:0] rd_q;
    logic                  drive;

    sp_sync_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (cs),
        .we    (we),
        .addr  (addr),
        .wdata (data),
        .rdata (rd_q)
    );

    // Never drive while we is high, so the RAM cannot fight the bus master.
    assign drive = cs && oe && !we;
    assign data  = drive ? rd_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sp_sync_ram.sv
// tb/tb_sp_sync_ram.sv - directed vector bench for sp_sync_ram
module tb_sp_sync_ram;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam logic [DW-1:0] ZV = '1;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] val;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [AW-1:0] addr;
    logic          cs;
    logic          we;
    logic          oe;
    logic [DW-1:0] drv;
    logic          drv_en;
    wire  [DW-1:0] data;

    int total;
    int bad;

    vec_t vecs [60];

    assign data = drv_en ? drv : {DW{1'bz}};
    pullup (data);

    sp_sync_ram #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .data (data),
        .cs   (cs),
        .we   (we),
        .oe   (oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] v);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; oe = 1'b0; addr = a; drv = v; drv_en = 1'b1;
        @(posedge clk);
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        @(negedge clk);
        drv_en = 1'b0; cs = 1'b1; we = 1'b0; oe = 1'b1; addr = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            vecs[i].we   = 1'b1;
            vecs[i].addr = AW'(i);
            vecs[i].val  = DW'(i / 10);
            vecs[30 + i].we   = 1'b0;
            vecs[30 + i].addr = AW'(i);
            vecs[30 + i].val  = DW'(i / 10);
        end

        // Reset while selected for read: bus shows the cleared register.
        rst = 1'b1; cs = 1'b1; oe = 1'b1; we = 1'b0; addr = '0; drv = '0; drv_en = 1'b0;
        #3;
        check("reset_bus_zero", data, '0);
        cs = 1'b0;
        #1;
        check("reset_deselect_z", data, ZV);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_reset_z", data, ZV);

        for (int i = 0; i < 60; i++) begin
            if (vecs[i].we) begin
                do_write(vecs[i].addr, vecs[i].val);
            end else begin
                do_read(vecs[i].addr);
                check($sformatf("table_read_a%0d", vecs[i].addr), data, vecs[i].val);
            end
        end

        // Write-then-read back-to-back, with oe high during the write.
        @(negedge clk);
        cs = 1'b1; we = 1'b1; oe = 1'b1; addr = 8'd5; drv = 32'hDEADBEEF; drv_en = 1'b1;
        @(posedge clk);
        do_read(8'd5);
        check("wr_rd_b2b", data, 32'hDEADBEEF);
        #1;
        cs = 1'b1; we = 1'b1; oe = 1'b1; addr = 8'd40;
        #1;
        check("we_oe_no_drive", data, ZV);
        cs = 1'b0; we = 1'b0;

        // Combinational release and re-drive without a clock edge.
        do_read(8'd12);
        check("read_a12", data, 32'd1);
        #1 cs = 1'b0;
        #1 check("cs_drop_z", data, ZV);
        #1 begin cs = 1'b1; oe = 1'b0; end
        #1 check("oe_low_z", data, ZV);
        #1 oe = 1'b1;
        #1 check("oe_raise_redrive", data, 32'd1);

        // Asynchronous reset mid-read; memory must survive it.
        do_read(8'd22);
        check("read_a22", data, 32'd2);
        #1 rst = 1'b1;
        #1 check("async_reset_zero", data, '0);
        @(negedge clk);
        rst = 1'b0; cs = 1'b0;
        @(posedge clk);
        #1 cs = 1'b1;
        #1 check("held_zero_after_reset", data, '0);
        do_read(8'd22);
        check("mem_kept_a22", data, 32'd2);

        // Extremes of the address range do not alias.
        do_write(8'hFF, 32'hA5A5A5A5);
        do_write(8'h00, 32'h5A5A5A5A);
        do_read(8'hFF);
        check("top_addr", data, 32'hA5A5A5A5);
        do_read(8'h00);
        check("bottom_addr", data, 32'h5A5A5A5A);
        do_read(8'd5);
        check("a5_still_deadbeef", data, 32'hDEADBEEF);

        @(negedge clk);
        cs = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
